sha1_block_feeder: RTL and testbench

Upstream stage of the SHA-1 hasher. It reads a message frame from the dual-port SRAM through port A and applies SHA-1 padding: a 0x80 marker, zero fill, and a 64-bit big-endian bit length. It streams the padded message to the compression core as 512-bit blocks, one 32-bit word per handshake, flagging the final block. This replaces ad-hoc padding inside the hash core.

---
 rtl/sha1_pkg.sv | 26 ++
 rtl/sha1_pad_word.sv | 47 ++++
 rtl/sha1_block_feeder.sv | 158 +++++++++++++++
 tb/tb_sha1_block_feeder.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha1_pkg.sv
// ============================================================================
// sha1_pkg : shared types and constants for the SHA-1 block feeder.
// Revision : 1.0
// ============================================================================
`default_nettype none

package sha1_pkg;

  localparam int         SHA1_BLOCK_WORDS = 16;
  localparam logic [7:0] SHA1_PAD_BYTE    = 8'h80;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_GEN   = 3'd3,
    ST_OUT   = 3'd4
  } feed_state_e;

  function automatic logic [31:0] sha1_byteswap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/sha1_pad_word.sv
// ============================================================================
// sha1_pad_word : maps (raw word, word number, size, NB) to the padded word.
// Revision      : 1.0
// ============================================================================
`default_nettype none

module sha1_pad_word
  import sha1_pkg::*;
(
  input  logic [31:0] raw_i,
  input  logic [29:0] wnum_i,
  input  logic [31:0] size_i,
  input  logic [25:0] nb_i,
  output logic [31:0] word_o
);

  // Byte offsets widened so 4w+3 cannot wrap for the largest word number.
  logic [33:0] byte_base_d;
  logic [33:0] size_ext_d;
  logic [29:0] last_wnum_d;

  assign byte_base_d = {2'b00, wnum_i, 2'b00};
  assign size_ext_d  = {2'b00, size_i};
  assign last_wnum_d = {nb_i, 4'b0000} - 30'd1;

  always_comb begin
    word_o = '0;
    if (byte_base_d + 34'd3 < size_ext_d) begin
      word_o = raw_i;
    end else if (byte_base_d <= size_ext_d) begin
      // size - 4w equals size[1:0] here because 4w is word aligned.
      case (size_i[1:0])
        2'd0: word_o = {SHA1_PAD_BYTE, 24'h0};
        2'd1: word_o = {raw_i[31:24], SHA1_PAD_BYTE, 16'h0};
        2'd2: word_o = {raw_i[31:16], SHA1_PAD_BYTE, 8'h0};
        2'd3: word_o = {raw_i[31:8], SHA1_PAD_BYTE};
      endcase
    end else if (wnum_i == last_wnum_d - 30'd1) begin
      word_o = {29'b0, size_i[31:29]};
    end else if (wnum_i == last_wnum_d) begin
      word_o = {size_i[28:0], 3'b000};
    end
  end

endmodule

`default_nettype wire

// File: rtl/sha1_block_feeder.sv
// ============================================================================
// sha1_block_feeder : reads a message from SRAM port A, applies SHA-1 padding
//                     and streams 512-bit blocks one 32-bit word at a time.
// Option macro      : SHA1_FEEDER_BYTESWAP_EN (byte-reverse SRAM read data)
// Revision          : 1.0
// ============================================================================
`default_nettype none

module sha1_block_feeder
  import sha1_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              start_feed,
  input  logic [31:0]       message_addr,
  input  logic [31:0]       message_size,
  output logic              port_A_clk,
  output logic [ADDR_W-1:0] port_A_addr,
  output logic              port_A_we,
  output logic [31:0]       port_A_data_in,
  input  logic [31:0]       port_A_data_out,
  output logic [31:0]       blk_word,
  output logic [3:0]        blk_word_idx,
  output logic              blk_last,
  output logic              blk_word_valid,
  input  logic              blk_word_ready,
  output logic              busy,
  output logic              done
);

  feed_state_e       state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       size_q;
  logic [25:0]       nb_q;
  logic [3:0]        idx_q;
  logic [25:0]       blk_q;
  logic [31:0]       word_q;
  logic              valid_q;
  logic              last_q;
  logic              busy_q;
  logic              done_q;

  logic [25:0]       nb_d;
  logic [29:0]       wnum_d;
  logic [29:0]       wnum_next_d;
  logic [29:0]       last_wnum_d;
  logic              next_read_d;
  logic [31:0]       raw_d;
  logic [31:0]       pad_d;

  assign port_A_clk     = clk;
  assign port_A_we      = 1'b0;
  assign port_A_data_in = 32'h0;
  assign port_A_addr    = addr_q;
  assign blk_word       = word_q;
  assign blk_word_idx   = idx_q;
  assign blk_last       = last_q;
  assign blk_word_valid = valid_q;
  assign busy           = busy_q;
  assign done           = done_q;

  generate
    if (ADDR_W < 32) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^message_addr[31:ADDR_W];
    end
  endgenerate

  // Size is below 2^29, so the +8 cannot overflow 32 bits.
  assign nb_d        = 26'((message_size + 32'd8) >> 6) + 26'd1;
  assign wnum_d      = {blk_q, idx_q};
  assign wnum_next_d = wnum_d + 30'd1;
  assign last_wnum_d = {nb_q, 4'b0000} - 30'd1;
  assign next_read_d = ({wnum_next_d, 2'b00} < size_q);

`ifdef SHA1_FEEDER_BYTESWAP_EN
  assign raw_d = sha1_byteswap(port_A_data_out);
`else
  assign raw_d = port_A_data_out;
`endif

  sha1_pad_word u_pad (
    .raw_i  (raw_d),
    .wnum_i (wnum_d),
    .size_i (size_q),
    .nb_i   (nb_q),
    .word_o (pad_d)
  );

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      size_q  <= '0;
      nb_q    <= '0;
      idx_q   <= '0;
      blk_q   <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_feed) begin
            addr_q  <= message_addr[ADDR_W-1:0];
            size_q  <= message_size;
            nb_q    <= nb_d;
            idx_q   <= '0;
            blk_q   <= '0;
            last_q  <= (nb_d == 26'd1);
            busy_q  <= 1'b1;
            state_q <= (message_size != 32'd0) ? ST_FETCH : ST_GEN;
          end
        end
        ST_FETCH: begin
          state_q <= ST_WAIT;
        end
        ST_WAIT, ST_GEN: begin
          word_q  <= pad_d;
          valid_q <= 1'b1;
          state_q <= ST_OUT;
        end
        ST_OUT: begin
          if (blk_word_ready) begin
            valid_q <= 1'b0;
            if (wnum_d == last_wnum_d) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end else begin
              idx_q <= idx_q + 4'd1;
              if (idx_q == 4'(SHA1_BLOCK_WORDS - 1)) begin
                blk_q  <= blk_q + 26'd1;
                last_q <= (blk_q + 26'd1 == nb_q - 26'd1);
              end
              // Message words are contiguous, so the read address only steps on reads.
              if (next_read_d) begin
                addr_q  <= addr_q + 1'b1;
                state_q <= ST_FETCH;
              end else begin
                state_q <= ST_GEN;
              end
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sha1_block_feeder.sv
// ============================================================================
// tb_sha1_block_feeder : scoreboard bench for sha1_block_feeder.
// Revision             : 1.0
// ============================================================================
`default_nettype none

module tb_sha1_block_feeder;

  logic        clk = 1'b0;
  logic        nreset;
  logic        start_feed;
  logic [31:0] message_addr;
  logic [31:0] message_size;
  logic        port_A_clk;
  logic [15:0] port_A_addr;
  logic        port_A_we;
  logic [31:0] port_A_data_in;
  logic [31:0] port_A_data_out;
  logic [31:0] blk_word;
  logic [3:0]  blk_word_idx;
  logic        blk_last;
  logic        blk_word_valid;
  logic        blk_word_ready;
  logic        busy;
  logic        done;

  sha1_block_feeder #(.ADDR_W(16)) dut (
    .clk            (clk),
    .nreset         (nreset),
    .start_feed     (start_feed),
    .message_addr   (message_addr),
    .message_size   (message_size),
    .port_A_clk     (port_A_clk),
    .port_A_addr    (port_A_addr),
    .port_A_we      (port_A_we),
    .port_A_data_in (port_A_data_in),
    .port_A_data_out(port_A_data_out),
    .blk_word       (blk_word),
    .blk_word_idx   (blk_word_idx),
    .blk_last       (blk_last),
    .blk_word_valid (blk_word_valid),
    .blk_word_ready (blk_word_ready),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:255];
  always @(posedge clk) port_A_data_out <= mem[port_A_addr[7:0]];

  typedef struct {
    logic [31:0] word;
    logic [3:0]  idx;
    logic        last;
    int          gap;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          acc_cnt = 0;
  int          last_acc_cyc = 0;
  int          first_cyc = -1;
  int          t0 = 0;
  bit          want_first = 0;
  bit          done_seen = 0;
  bit          throttle = 0;
  bit          check_gap = 0;
  bit          stall_prev = 0;
  logic [31:0] sv_word;
  logic [3:0]  sv_idx;
  logic        sv_last;
  logic [31:0] cap [0:63];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Byte-level reference: message bytes, 0x80 marker, zeros, 64-bit length.
  function automatic logic [7:0] exp_byte(input int base, input int size, input int nb, input int j);
    logic [31:0] mw;
    logic [63:0] bitlen;
    bitlen = 64'(size) * 64'd8;
    if (j < size) begin
      mw = mem[(base + j / 4) & 255];
`ifdef SHA1_FEEDER_BYTESWAP_EN
      mw = {mw[7:0], mw[15:8], mw[23:16], mw[31:24]};
`endif
      return mw[31 - 8 * (j % 4) -: 8];
    end
    if (j == size) return 8'h80;
    if (j >= 64 * nb - 8) return bitlen[8 * (64 * nb - 1 - j) +: 8];
    return 8'h00;
  endfunction

  task automatic push_expected(input int base, input int size);
    int   nb;
    exp_t e;
    nb = (size + 8) / 64 + 1;
    for (int w = 0; w < 16 * nb; w++) begin
      e.word = '0;
      for (int k = 0; k < 4; k++) e.word = {e.word[23:0], exp_byte(base, size, nb, 4 * w + k)};
      e.idx  = 4'(w % 16);
      e.last = (w / 16 == nb - 1);
      e.gap  = (w == 0) ? 0 : ((4 * w < size) ? 3 : 2);
      sb.push_back(e);
    end
  endtask

  initial begin
    blk_word_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      blk_word_ready = throttle ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  // Monitor: pops the scoreboard on every accepted word.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (nreset) begin
        if (stall_prev) begin
          chk("stall_valid", blk_word_valid, 1);
          chk("stall_word", blk_word, sv_word);
          chk("stall_idx", blk_word_idx, sv_idx);
          chk("stall_last", blk_last, sv_last);
        end
        if (blk_word_valid && want_first) begin
          first_cyc  = cyc;
          want_first = 0;
        end
        if (blk_word_valid && blk_word_ready) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra_word: got %h with nothing expected", blk_word);
          end else begin
            e = sb.pop_front();
            chk("word", blk_word, e.word);
            chk("word_idx", blk_word_idx, e.idx);
            chk("last", blk_last, e.last);
            if (check_gap && e.gap > 0) chk("word_gap", cyc - last_acc_cyc, e.gap);
          end
          if (acc_cnt < 64) cap[acc_cnt] = blk_word;
          acc_cnt++;
          last_acc_cyc = cyc;
        end
        if (done) begin
          chk("done_timing", cyc - last_acc_cyc, 1);
          chk("busy_at_done", busy, 0);
          done_seen = 1;
        end
        stall_prev = blk_word_valid && !blk_word_ready;
        sv_word    = blk_word;
        sv_idx     = blk_word_idx;
        sv_last    = blk_last;
      end else begin
        stall_prev = 0;
      end
    end
  end

  task automatic start_stream(input int base, input int size);
    acc_cnt   = 0;
    done_seen = 0;
    first_cyc = -1;
    @(negedge clk);
    message_addr = base;
    message_size = size;
    start_feed   = 1'b1;
    want_first   = 1;
    @(negedge clk);
    start_feed = 1'b0;
    t0 = cyc;
  endtask

  task automatic run_stream(input string tag, input int base, input int size, input bit thr, input bit poke);
    int nb;
    int guard;
    nb = (size + 8) / 64 + 1;
    push_expected(base, size);
    throttle  = thr;
    check_gap = !thr;
    start_stream(base, size);
    if (poke) begin
      repeat (7) @(negedge clk);
      message_size = 0;
      start_feed   = 1'b1;
      @(negedge clk);
      start_feed = 1'b0;
    end
    guard = 0;
    while (!done_seen && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    chk({tag, "_finished"}, done_seen, 1);
    chk({tag, "_latency"}, first_cyc - t0, (size > 0) ? 2 : 1);
    chk({tag, "_count"}, acc_cnt, 16 * nb);
    chk({tag, "_final_addr"}, port_A_addr, (base + ((size > 0) ? (size + 3) / 4 - 1 : 0)) & 16'hFFFF);
    chk({tag, "_sb_empty"}, sb.size(), 0);
    sb.delete();
    throttle = 0;
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, blk_word_valid, 0);
    chk({tag, "_word"}, blk_word, 0);
    chk({tag, "_idx"}, blk_word_idx, 0);
    chk({tag, "_last"}, blk_last, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_addr"}, port_A_addr, 0);
    chk({tag, "_we"}, port_A_we, 0);
  endtask

  initial begin
    int guard;
    nreset       = 1'b0;
    start_feed   = 1'b0;
    message_addr = '0;
    message_size = '0;
    for (int i = 0; i < 256; i++) mem[i] = {8'(i) ^ 8'hA5, 8'(i), 8'h3C, ~8'(i)};
`ifdef SHA1_FEEDER_BYTESWAP_EN
    mem[8'h20] = 32'hFF636261;
`else
    mem[8'h20] = 32'h616263FF;
`endif
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    nreset = 1'b1;

    run_stream("size0", 32'h10, 0, 0, 0);
    chk("size0_w0", cap[0], 32'h80000000);
    chk("size0_w15", cap[15], 32'h0);

    run_stream("size3", 32'h20, 3, 0, 0);
    chk("size3_w0", cap[0], 32'h61626380);
    chk("size3_w15", cap[15], 32'h18);

    run_stream("size55", 32'h30, 55, 0, 0);
    chk("size55_w13_lane0", cap[13][7:0], 8'h80);
    chk("size55_w15", cap[15], 32'h1B8);

    run_stream("size56", 32'h40, 56, 0, 0);
    chk("size56_b0w14", cap[14], 32'h80000000);
    chk("size56_b1w0", cap[16], 32'h0);
    chk("size56_b1w15", cap[31], 32'h1C0);

    run_stream("size64", 32'h80, 64, 1, 1);
    chk("size64_b1w0", cap[16], 32'h80000000);
    chk("size64_b1w15", cap[31], 32'h200);

    // Abort mid-block 0, then restart.
    push_expected(32'h80, 64);
    check_gap = 0;
    start_stream(32'h80, 64);
    guard = 0;
    while (acc_cnt < 5 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("abort_progress", acc_cnt >= 5, 1);
    nreset = 1'b0;
    @(negedge clk);
    check_reset_outputs("abort");
    sb.delete();
    nreset = 1'b1;
    run_stream("restart", 32'h20, 3, 0, 0);
    chk("restart_w0", cap[0], 32'h61626380);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
